// File: rtl/fpu_pkg.sv
// Shared types and widths for the fcvtws arbiter slice.
package fpu_pkg;

  localparam int unsigned FP32_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } cvt_state_t;

endpackage

// File: rtl/fcvtws.sv
// fcvtws: fp32 -> signed int32, round to nearest with ties away from zero.
// Ports:
//   x_i      fp32 operand
//   y_c_o    signed int32 result (combinational)
//   exc_c_o  set for |x| >= 2^31, infinities and NaNs (combinational)
module fcvtws
  import fpu_pkg::*;
(
  input  logic [FP32_W-1:0] x_i,
  output logic [FP32_W-1:0] y_c_o,
  output logic              exc_c_o
);

  logic        sign;
  logic [7:0]  expo;
  logic [23:0] mant;
  logic [4:0]  sh;
  logic [32:0] twice;
  logic [31:0] mag;

  assign sign = x_i[31];
  assign expo = x_i[30:23];
  assign mant = {1'b1, x_i[22:0]};

  // Shift so bit 0 of twice is the first fraction bit (the half bit).
  always_comb begin
    y_c_o   = '0;
    exc_c_o = 1'b0;
    sh      = '0;
    twice   = '0;
    mag     = '0;
    if (expo >= 8'd158) begin
      exc_c_o = 1'b1;
      if (expo == 8'hFF && x_i[22:0] != 23'd0) begin
        y_c_o = 32'h7FFF_FFFF;
      end else begin
        y_c_o = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (expo >= 8'd126) begin
      sh    = 5'(expo - 8'd126);
      twice = 33'(({32'd0, mant} << sh) >> 23);
      mag   = twice[32:1] + 32'(twice[0]);
      y_c_o = sign ? (~mag + 32'd1) : mag;
    end
  end

endmodule

// File: rtl/fcvtws_arbiter.sv
// Round-robin arbiter sharing one fcvtws between requester 0 (int pipe) and
// requester 1 (FPU issue). One op in flight; result returned to its issuer.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   reqN_valid/ready/x/tag       request channel per requester (ready is combinational)
//   respN_valid/ready/y/exc/tag  response channel per requester
//   exc_count                    saturating count of delivered exception responses
module fcvtws_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FP32_W-1:0] req0_x,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FP32_W-1:0] req1_x,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [FP32_W-1:0] resp0_y,
  output logic              resp0_exc,
  output logic [TAG_W-1:0]  resp0_tag,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [FP32_W-1:0] resp1_y,
  output logic              resp1_exc,
  output logic [TAG_W-1:0]  resp1_tag,
  output logic [CNT_W-1:0]  exc_count
);

  cvt_state_t        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              op_owner_q;
  logic [FP32_W-1:0] op_x_q;
  logic [TAG_W-1:0]  op_tag_q;
  logic              res_owner_q;
  logic [FP32_W-1:0] res_y_q;
  logic              res_exc_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic [CNT_W-1:0]  exc_count_q;

  logic              hold_done;
  logic              grant;
  logic              winner;
  logic [FP32_W-1:0] cvt_y;
  logic              cvt_exc;

  fcvtws u_fcvtws (
    .x_i     (op_x_q),
    .y_c_o   (cvt_y),
    .exc_c_o (cvt_exc)
  );

  // Grant and next-state: a new op may be granted in IDLE or as the held
  // response is consumed, so back-to-back ops see no idle bubble.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    hold_done  = (state_q == HOLD) && (res_owner_q ? resp1_ready : resp0_ready);
    winner     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    grant      = ((state_q == IDLE) || hold_done) && (req0_valid || req1_valid);
    if (grant) begin
      req0_ready = ~winner;
      req1_ready = winner;
      rr_ptr_d   = ~winner;
    end
    case (state_q)
      IDLE:    if (grant) state_d = CONV;
      CONV:    state_d = HOLD;
      HOLD:    if (hold_done) state_d = grant ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, op register (loaded on grant), result register (loaded in CONV).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_owner_q  <= 1'b0;
      op_x_q      <= '0;
      op_tag_q    <= '0;
      res_owner_q <= 1'b0;
      res_y_q     <= '0;
      res_exc_q   <= 1'b0;
      res_tag_q   <= '0;
      exc_count_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        op_owner_q <= winner;
        op_x_q     <= winner ? req1_x : req0_x;
        op_tag_q   <= winner ? req1_tag : req0_tag;
      end
      if (state_q == CONV) begin
        res_owner_q <= op_owner_q;
        res_y_q     <= cvt_y;
        res_exc_q   <= cvt_exc;
        res_tag_q   <= op_tag_q;
      end
      if (hold_done && res_exc_q && (exc_count_q != '1)) begin
        exc_count_q <= exc_count_q + CNT_W'(1);
      end
    end
  end

  assign resp0_valid = (state_q == HOLD) && !res_owner_q;
  assign resp1_valid = (state_q == HOLD) && res_owner_q;
  assign resp0_y     = res_y_q;
  assign resp1_y     = res_y_q;
  assign resp0_exc   = res_exc_q;
  assign resp1_exc   = res_exc_q;
  assign resp0_tag   = res_tag_q;
  assign resp1_tag   = res_tag_q;
  assign exc_count   = exc_count_q;

endmodule
